// File: rtl/ponte_motor.sv
// ponte_motor: debounced two-request H-bridge controller with dead-time braking between drive phases.
// Defining PONTE_MOTOR_RUN_TIMEOUT_EN adds a run-length limit that trips a latched FAULT state.
module ponte_motor #(
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned DEAD_TIME  = 8,
  parameter int unsigned MAX_RUN    = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       antHorario,
  input  logic       horario,
  output logic       motor_ccw,
  output logic       motor_cw,
  output logic       brake,
  output logic       fault,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CW    = 3'd1,
    S_CCW   = 3'd2,
    S_DEAD  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [3:0]  FILT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [15:0] DEAD_LAST = 16'(DEAD_TIME);

  state_t      r_state;
  logic        r_filt_h;
  logic        r_filt_a;
  logic [3:0]  r_cnt_h;
  logic [3:0]  r_cnt_a;
  logic [15:0] r_dead_cnt;

  logic w_req_cw;
  logic w_req_ccw;
  logic w_req_none;
  logic w_run_done;

  // Each filter counts consecutive raw samples that disagree with its output;
  // any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_filt_h <= 1'b0;
      r_filt_a <= 1'b0;
      r_cnt_h  <= '0;
      r_cnt_a  <= '0;
    end else begin
      if (horario == r_filt_h) begin
        r_cnt_h <= '0;
      end else if (r_cnt_h >= FILT_LAST) begin
        r_filt_h <= horario;
        r_cnt_h  <= '0;
      end else begin
        r_cnt_h <= r_cnt_h + 4'd1;
      end

      if (antHorario == r_filt_a) begin
        r_cnt_a <= '0;
      end else if (r_cnt_a >= FILT_LAST) begin
        r_filt_a <= antHorario;
        r_cnt_a  <= '0;
      end else begin
        r_cnt_a <= r_cnt_a + 4'd1;
      end
    end
  end

  assign w_req_cw   = r_filt_h & ~r_filt_a;
  assign w_req_ccw  = r_filt_a & ~r_filt_h;
  assign w_req_none = ~r_filt_h & ~r_filt_a;

  // The dead-time counter holds the 1-based index of the current DEAD cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_dead_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_cw)       r_state <= S_CW;
          else if (w_req_ccw) r_state <= S_CCW;
        end
        S_CW: begin
          if (w_run_done) begin
            r_state <= S_FAULT;
          end else if (!w_req_cw) begin
            r_state    <= S_DEAD;
            r_dead_cnt <= 16'd1;
          end
        end
        S_CCW: begin
          if (w_run_done) begin
            r_state <= S_FAULT;
          end else if (!w_req_ccw) begin
            r_state    <= S_DEAD;
            r_dead_cnt <= 16'd1;
          end
        end
        S_DEAD: begin
          if (r_dead_cnt >= DEAD_LAST)    r_state    <= S_IDLE;
          else if (r_dead_cnt != 16'hFFFF) r_dead_cnt <= r_dead_cnt + 16'd1;
        end
        S_FAULT: begin
          if (w_req_none) begin
            r_state    <= S_DEAD;
            r_dead_cnt <= 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef PONTE_MOTOR_RUN_TIMEOUT_EN
  localparam logic [15:0] RUN_LAST = 16'(MAX_RUN);

  logic [15:0] r_run_cnt;

  // Drive phases are only entered from IDLE, so holding 1 outside drive
  // makes the first drive cycle count as cycle 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run_cnt <= '0;
    end else if (r_state == S_CW || r_state == S_CCW) begin
      if (r_run_cnt != 16'hFFFF) r_run_cnt <= r_run_cnt + 16'd1;
    end else begin
      r_run_cnt <= 16'd1;
    end
  end

  assign w_run_done = (r_run_cnt >= RUN_LAST);
  assign fault      = (r_state == S_FAULT);
`else
  assign w_run_done = 1'b0;
  assign fault      = 1'b0;
`endif

  assign motor_cw    = (r_state == S_CW);
  assign motor_ccw   = (r_state == S_CCW);
  assign brake       = (r_state == S_DEAD) || (r_state == S_FAULT);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ponte_motor.sv
// tb_ponte_motor: randomized and directed checks of ponte_motor against a cycle-level reference model.
// Outputs are compared as {motor_cw, motor_ccw, brake, fault}.
module tb_ponte_motor;

  localparam int FL = 4;
  localparam int DT = 8;
  localparam int MR = 1000;
`ifdef PONTE_MOTOR_RUN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       antHorario = 1'b0;
  logic       horario = 1'b0;
  logic       motor_ccw, motor_cw, brake, fault;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  ponte_motor #(.FILTER_LEN(FL), .DEAD_TIME(DT), .MAX_RUN(MR)) dut (
    .clk(clk), .rst(rst), .antHorario(antHorario), .horario(horario),
    .motor_ccw(motor_ccw), .motor_cw(motor_cw), .brake(brake), .fault(fault),
    .o_dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  // Mode: 0 idle, 1 clockwise, 2 anticlockwise, 3 braking (dead time), 4 fault.
  int   m_mode = 0;
  int   m_dead_left = 0;
  int   m_run = 0;
  bit   m_fh = 0, m_fa = 0;
  bit   hist_h[$], hist_a[$];
  logic [3:0] exp_q[$];

  // A filtered value flips once the last FL raw samples all agree with each other and differ from it.
  function automatic bit filter_next(input bit filt, input bit hist[$]);
    if (hist.size() < FL) return filt;
    foreach (hist[i]) if (hist[i] == filt) return filt;
    return !filt;
  endfunction

  function automatic void model_step(input bit r, input bit h, input bit a);
    int nm;
    bit keep;
    if (r) begin
      m_mode = 0; m_fh = 0; m_fa = 0; m_run = 0; m_dead_left = 0;
      hist_h.delete(); hist_a.delete();
      return;
    end
    nm = m_mode;
    case (m_mode)
      0: if (m_fh && !m_fa) begin nm = 1; m_run = 1; end
         else if (m_fa && !m_fh) begin nm = 2; m_run = 1; end
      1, 2: begin
        keep = (m_mode == 1) ? (m_fh && !m_fa) : (m_fa && !m_fh);
        if (TO_EN && m_run >= MR) nm = 4;
        else if (!keep) begin nm = 3; m_dead_left = DT; end
        else m_run++;
      end
      3: if (m_dead_left <= 1) nm = 0; else m_dead_left--;
      4: if (!m_fh && !m_fa) begin nm = 3; m_dead_left = DT; end
      default: nm = 0;
    endcase
    m_mode = nm;
    hist_h.push_back(h); if (hist_h.size() > FL) void'(hist_h.pop_front());
    hist_a.push_back(a); if (hist_a.size() > FL) void'(hist_a.pop_front());
    m_fh = filter_next(m_fh, hist_h);
    m_fa = filter_next(m_fa, hist_a);
  endfunction

  function automatic logic [3:0] model_out();
    return {m_mode == 1, m_mode == 2, m_mode == 3 || m_mode == 4, m_mode == 4};
  endfunction

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    model_step(rst, horario, antHorario);
    exp_q.push_back(model_out());
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [3:0] exp;
    rst = 1'b1; horario = 1'b0; antHorario = 1'b0;
    tick(); void'(exp_q.pop_front());
    tick(); exp = exp_q.pop_front();
    rst = 1'b0;
    n_tests++;
    if ({motor_cw, motor_ccw, brake, fault} !== 4'b0000 || exp !== 4'b0000) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 0000", {motor_cw, motor_ccw, brake, fault});
    end
    n_tests++;
    if (dbg_state !== 3'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d expected 0 (idle)", dbg_state);
    end
  endtask

  task automatic test_start_cw();
    logic [3:0] exp;
    int first_cw = -1;
    horario = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(); exp = exp_q.pop_front();
      n_tests++;
      if ({motor_cw, motor_ccw, brake, fault} !== exp) begin
        n_fail++; $display("FAIL start_cw_cycle%0d: got %b expected %b", k, {motor_cw, motor_ccw, brake, fault}, exp);
      end
      if (motor_cw === 1'b1 && first_cw < 0) first_cw = k;
    end
    n_tests++;
    if (first_cw != FL + 1) begin
      n_fail++; $display("FAIL start_cw_latency: got %0d edges expected %0d", first_cw, FL + 1);
    end
  endtask

  task automatic test_reversal();
    logic [3:0] exp;
    int brake_cycles = 0, idle_gap = 0, first_ccw = -1, last_brake = -1;
    bit prev_cw = motor_cw, prev_ccw = motor_ccw;
    horario = 1'b0; antHorario = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick(); exp = exp_q.pop_front();
      n_tests++;
      if ({motor_cw, motor_ccw, brake, fault} !== exp) begin
        n_fail++; $display("FAIL reversal_cycle%0d: got %b expected %b", k, {motor_cw, motor_ccw, brake, fault}, exp);
      end
      if ((motor_cw && (motor_ccw || prev_ccw)) || (motor_ccw && prev_cw)) begin
        n_fail++; $display("FAIL reversal_overlap: cycle %0d cw=%b ccw=%b expected no overlap", k, motor_cw, motor_ccw);
      end
      if (brake) begin brake_cycles++; last_brake = k; end
      if (motor_ccw && first_ccw < 0) first_ccw = k;
      prev_cw = motor_cw; prev_ccw = motor_ccw;
    end
    idle_gap = first_ccw - last_brake - 1;
    n_tests++;
    if (brake_cycles != DT) begin
      n_fail++; $display("FAIL reversal_dead_len: got %0d expected %0d", brake_cycles, DT);
    end
    n_tests++;
    if (first_ccw < 0 || idle_gap != 1) begin
      n_fail++; $display("FAIL reversal_idle_gap: got %0d expected 1", idle_gap);
    end
  endtask

  task automatic test_glitch();
    logic [3:0] exp;
    rst = 1'b1; horario = 1'b0; antHorario = 1'b0;
    tick(); void'(exp_q.pop_front());
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      horario = (k < 3);
      tick(); exp = exp_q.pop_front();
      n_tests++;
      if ({motor_cw, motor_ccw, brake, fault} !== 4'b0000 || exp !== 4'b0000) begin
        n_fail++; $display("FAIL glitch_cycle%0d: got %b expected 0000", k, {motor_cw, motor_ccw, brake, fault});
      end
    end
  endtask

  task automatic test_both_high();
    logic [3:0] exp;
    horario = 1'b1; antHorario = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick(); exp = exp_q.pop_front();
      n_tests++;
      if ({motor_cw, motor_ccw, brake, fault} !== 4'b0000 || exp !== 4'b0000) begin
        n_fail++; $display("FAIL both_high_idle%0d: got %b expected 0000", k, {motor_cw, motor_ccw, brake, fault});
      end
    end
    antHorario = 1'b0;
    for (int k = 0; k < FL + 2; k++) begin tick(); void'(exp_q.pop_front()); end
    n_tests++;
    if (motor_cw !== 1'b1) begin
      n_fail++; $display("FAIL both_high_setup_cw: got %b expected 1", motor_cw);
    end
    antHorario = 1'b1;
    for (int k = 1; k <= FL + 1; k++) begin
      tick(); exp = exp_q.pop_front();
      n_tests++;
      if ({motor_cw, motor_ccw, brake, fault} !== exp) begin
        n_fail++; $display("FAIL both_high_cw%0d: got %b expected %b", k, {motor_cw, motor_ccw, brake, fault}, exp);
      end
    end
    n_tests++;
    if ({motor_cw, motor_ccw, brake} !== 3'b001) begin
      n_fail++; $display("FAIL both_high_dead: got %b expected 001", {motor_cw, motor_ccw, brake});
    end
  endtask

  task automatic test_run_timeout();
    logic [3:0] exp;
    int cw_cycles = 0;
    int hold = TO_EN ? MR + 30 : 2100;
    rst = 1'b1; horario = 1'b0; antHorario = 1'b0;
    tick(); void'(exp_q.pop_front());
    rst = 1'b0; horario = 1'b1;
    for (int k = 0; k < hold; k++) begin
      tick(); exp = exp_q.pop_front();
      n_tests++;
      if ({motor_cw, motor_ccw, brake, fault} !== exp) begin
        n_fail++; $display("FAIL timeout_hold%0d: got %b expected %b", k, {motor_cw, motor_ccw, brake, fault}, exp);
      end
      if (motor_cw) cw_cycles++;
    end
    if (TO_EN) begin
      n_tests++;
      if (cw_cycles != MR || fault !== 1'b1 || brake !== 1'b1) begin
        n_fail++; $display("FAIL timeout_trip: cw_cycles=%0d fault=%b brake=%b expected %0d 1 1", cw_cycles, fault, brake, MR);
      end
      horario = 1'b0;
      for (int k = 0; k < FL + DT + 4; k++) begin
        tick(); exp = exp_q.pop_front();
        n_tests++;
        if ({motor_cw, motor_ccw, brake, fault} !== exp) begin
          n_fail++; $display("FAIL timeout_release%0d: got %b expected %b", k, {motor_cw, motor_ccw, brake, fault}, exp);
        end
      end
      n_tests++;
      if ({motor_cw, motor_ccw, brake, fault} !== 4'b0000) begin
        n_fail++; $display("FAIL timeout_recover: got %b expected 0000", {motor_cw, motor_ccw, brake, fault});
      end
    end else begin
      n_tests++;
      if (cw_cycles < 2000 || motor_cw !== 1'b1 || fault !== 1'b0) begin
        n_fail++; $display("FAIL no_timeout_hold: cw_cycles=%0d cw=%b fault=%b expected >=2000 1 0", cw_cycles, motor_cw, fault);
      end
    end
  endtask

  task automatic test_reset_mid_dead();
    logic [3:0] exp;
    int first_cw = -1;
    int waited = 0;
    rst = 1'b1; horario = 1'b0; antHorario = 1'b0;
    tick(); void'(exp_q.pop_front());
    rst = 1'b0; horario = 1'b1;
    for (int k = 0; k < FL + 2; k++) begin tick(); void'(exp_q.pop_front()); end
    horario = 1'b0;
    while (brake !== 1'b1 && waited < 20) begin tick(); void'(exp_q.pop_front()); waited++; end
    n_tests++;
    if (brake !== 1'b1) begin
      n_fail++; $display("FAIL mid_dead_reach: brake=%b expected 1 within 20 cycles", brake);
    end
    tick(); void'(exp_q.pop_front());
    tick(); void'(exp_q.pop_front());
    rst = 1'b1;
    tick(); exp = exp_q.pop_front();
    rst = 1'b0;
    n_tests++;
    if ({motor_cw, motor_ccw, brake, fault} !== exp || exp !== 4'b0000) begin
      n_fail++; $display("FAIL mid_dead_reset: got %b expected 0000", {motor_cw, motor_ccw, brake, fault});
    end
    n_tests++;
    if (dbg_state !== 3'd0) begin
      n_fail++; $display("FAIL mid_dead_state: got %0d expected 0 (idle)", dbg_state);
    end
    horario = 1'b1;
    for (int k = 1; k <= FL + 3; k++) begin
      tick(); exp = exp_q.pop_front();
      n_tests++;
      if ({motor_cw, motor_ccw, brake, fault} !== exp) begin
        n_fail++; $display("FAIL mid_dead_redrive%0d: got %b expected %b", k, {motor_cw, motor_ccw, brake, fault}, exp);
      end
      if (motor_cw === 1'b1 && first_cw < 0) first_cw = k;
    end
    n_tests++;
    if (first_cw != FL + 1) begin
      n_fail++; $display("FAIL mid_dead_latency: got %0d edges expected %0d", first_cw, FL + 1);
    end
  endtask

  task automatic test_random();
    logic [3:0] exp;
    bit prev_cw = motor_cw, prev_ccw = motor_ccw;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 5) == 0) horario = ~horario;
      if ($urandom_range(0, 5) == 0) antHorario = ~antHorario;
      rst = ($urandom_range(0, 299) == 0);
      tick(); exp = exp_q.pop_front();
      n_tests++;
      if ({motor_cw, motor_ccw, brake, fault} !== exp) begin
        n_fail++; $display("FAIL random_cycle%0d: got %b expected %b", k, {motor_cw, motor_ccw, brake, fault}, exp);
      end
      if ((motor_cw && (motor_ccw || prev_ccw)) || (motor_ccw && prev_cw)) begin
        n_fail++; $display("FAIL random_overlap: cycle %0d cw=%b ccw=%b expected no overlap", k, motor_cw, motor_ccw);
      end
      prev_cw = motor_cw; prev_ccw = motor_ccw;
    end
    rst = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_start_cw();
    test_reversal();
    test_glitch();
    test_both_high();
    test_run_timeout();
    test_reset_mid_dead();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
